uart_peripheral: RTL
====================

# uart_peripheral

Byte-oriented UART transceiver that sits directly behind the processor datapath's UART hooks. It accepts TX bytes when the datapath asserts its UART write enable with `rs2[7:0]`. It returns RX bytes as a 32-bit word that the datapath muxes into the register-file write port on its UART read enable. Buffering on both directions is FIFO-based; baud timing is derived from the single system clock by an integer divider.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: system clocks per UART bit (100 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, 8: entries per FIFO; power of two, ≥ 2.

Ports:
- `clk` in 1: the single system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `write_en` in 1: push `write_data` into the TX FIFO.
- `write_data` in 8: TX byte.
- `read_en` in 1: pop the RX FIFO head.
- `read_data` out 32: `{24'h0, rx_head}` if RX non-empty, else `32'hFFFF_FFFF`; combinational.
- `err_clear` in 1: clear sticky error flags.
- `uart_rx` in 1: serial input, asynchronous.
- `uart_tx` out 1: serial output, registered, idle high.
- `tx_full` out 1: TX FIFO full.
- `rx_empty` out 1: RX FIFO empty.
- `tx_busy` out 1: TX FSM not IDLE or TX FIFO non-empty.
- `rx_overrun` out 1: sticky; byte received while RX FIFO full.
- `rx_frame_err` out 1: sticky; stop bit sampled low.

## Operation
- **Frame format:** 8N1, LSB first.
- **TX FIFO push:**
  - Accepted on an edge with `write_en` and (not full, or the TX FSM pops on the same edge).
  - Otherwise the byte is silently dropped.
- **TX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty: pop the FIFO, load the shift register, drive `uart_tx`=0.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA shifts 8 bits, each held `CLKS_PER_BIT` cycles.
  - STOP drives 1 for `CLKS_PER_BIT` cycles, then goes directly to START if the FIFO is non-empty, else to IDLE.
- **RX input:** `uart_rx` passes through a 2-flop synchronizer (reset value 1).
- **RX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized low level.
  - START: at count `CLKS_PER_BIT/2`, if the line is high, treat as a false start and return to IDLE; else zero the counter and enter DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles (mid-bit) for 8 bits.
  - STOP: sample once at mid-bit, then return to IDLE.
    - If the stop bit is 1 and the FIFO is not full, push the byte.
    - If the stop bit is 1 and the FIFO is full, drop the byte and set `rx_overrun`.
    - If the stop bit is 0, drop the byte and set `rx_frame_err`.
- **RX FIFO pop:** on an edge with `read_en` and not empty.
  - `read_en` on empty is a no-op.
  - Simultaneous push and pop on a full RX FIFO: both succeed; no overrun.
- **Error flags:** `err_clear` clears both flags. If an error event and `err_clear` occur on the same edge, the flag is set (set wins).
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits, so full and empty are unambiguous.

## Timing
- **Reset values:**
  - `uart_tx`=1, `tx_full`=0, `rx_empty`=1, `tx_busy`=0, `rx_overrun`=0, `rx_frame_err`=0.
  - `read_data`=`32'hFFFF_FFFF`.
  - Both FIFOs empty; both FSMs IDLE; all counters 0.
- **Reset mid-frame:** the frame is abandoned. `uart_tx` is 1 from the reset edge; buffered bytes are lost.
- **TX latency:** push on edge N with the FSM idle → `uart_tx` falls after edge N+1.
- **TX frame length:** exactly `10*CLKS_PER_BIT` cycles. Back-to-back frames have zero idle gap.
- **RX latency:** the byte appears in the FIFO (`rx_empty`=0) one edge after the stop-bit mid-sample.
  - This is 2 synchronizer cycles plus about `9.5*CLKS_PER_BIT` cycles after the start-bit falling edge.
- **`read_data`:** reflects the head in the same cycle, which matches single-cycle datapath register writeback. The pop takes effect at the same edge as the register write.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encodings (2-bit IDLE/START/DATA/STOP, shared by TX and RX).
  - `UART_EMPTY_WORD` = `32'hFFFF_FFFF`.
- **Sub-module `sync_fifo`:** parameterized width/depth, push/pop/full/empty/head. Instantiated twice (8-bit TX, 8-bit RX).
- TX and RX FSMs plus the synchronizer live in `uart_peripheral`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset, then idle 50 cycles → `uart_tx`=1, `read_data`=`FFFF_FFFF`, `rx_empty`=1, `tx_busy`=0.
- Write `8'hA5` → `uart_tx` reads 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles, starting the cycle after the push.
- Write 5 bytes on consecutive cycles while idle → all 5 transmitted back-to-back (first popped immediately), zero gap, 200 cycles total.
- Drive frame `8'h3C` on `uart_rx` → `rx_empty` falls; `read_data`=`32'h0000_003C`; after `read_en`, `read_data`=`FFFF_FFFF`.
- Drive 5 valid frames without reads → 4 bytes are kept in order and `rx_overrun`=1. Send a frame with stop=0 → `rx_frame_err`=1, FIFO unchanged. `err_clear` → both flags 0.
- Assert `reset` low mid TX data bit → `uart_tx`=1 after that edge, `tx_busy`=0. A 2-cycle `uart_rx` low glitch → no byte, no error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: FSM state encoding used by
// both the TX and RX engines, and the word returned when RX has no data.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam logic [31:0] UART_EMPTY_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_peripheral_if.sv
// Datapath-facing bus of the UART peripheral: TX byte writes, RX word
// reads, error clear and status flags.
interface uart_peripheral_if;

  logic        write_en;
  logic [7:0]  write_data;
  logic        read_en;
  logic [31:0] read_data;
  logic        err_clear;
  logic        tx_full;
  logic        rx_empty;
  logic        tx_busy;
  logic        rx_overrun;
  logic        rx_frame_err;

  // Datapath side.
  modport master (
    output write_en, write_data, read_en, err_clear,
    input  read_data, tx_full, rx_empty, tx_busy, rx_overrun, rx_frame_err
  );

  // Peripheral side.
  modport slave (
    input  write_en, write_data, read_en, err_clear,
    output read_data, tx_full, rx_empty, tx_busy, rx_overrun, rx_frame_err
  );

endinterface

// File: rtl/uart_peripheral_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head. A push into a full
// FIFO is accepted when a pop happens on the same edge; a pop on empty is
// ignored. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage write; contents need no reset since occupancy gates the head.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_peripheral.sv
// 8N1 UART transceiver behind the datapath UART hooks: TX bytes are queued
// in a FIFO and serialised back-to-back; RX frames are synchronised,
// mid-bit sampled and queued for the datapath to read as 32-bit words.
module uart_peripheral
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_uart_rx,
  output logic             o_uart_tx,
  uart_peripheral_if.slave bus_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

  // ---------------- FIFOs ----------------
  logic [7:0] w_tx_head;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_tx_pop;
  logic [7:0] w_rx_head;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic       w_rx_push;
  logic [7:0] r_rx_shift;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus_if.write_en),
    .i_data  (bus_if.write_data),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (bus_if.read_en),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // ---------------- TX engine ----------------
  uart_state_t      r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]       r_tx_idx, w_tx_idx_nxt;
  logic [7:0]       r_tx_shift, w_tx_shift_nxt;
  logic             r_tx_out, w_tx_out_nxt;

  // TX state register; the serial line itself is registered and idles high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_out   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_out   <= w_tx_out_nxt;
    end
  end

  // TX next state: bit timing, shifting, and popping the next byte.
  // STOP chains straight into START when more data is queued (no idle gap).
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_out_nxt   = r_tx_out;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_out_nxt = 1'b1;
        if (!w_tx_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_shift_nxt = w_tx_head;
          w_tx_out_nxt   = 1'b0;
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = '0;
          w_tx_out_nxt   = r_tx_shift[0];
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          w_tx_state_nxt = ST_DATA;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_idx == 3'd7) begin
            w_tx_out_nxt   = 1'b1;
            w_tx_state_nxt = ST_STOP;
          end else begin
            w_tx_out_nxt   = r_tx_shift[0];
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
            w_tx_idx_nxt   = r_tx_idx + 3'd1;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt = '0;
          if (!w_tx_empty) begin
            w_tx_pop       = 1'b1;
            w_tx_shift_nxt = w_tx_head;
            w_tx_out_nxt   = 1'b0;
            w_tx_state_nxt = ST_START;
          end else begin
            w_tx_state_nxt = ST_IDLE;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      default: w_tx_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- RX engine ----------------
  logic             r_rx_meta;
  logic             r_rx_sync;
  uart_state_t      r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]       r_rx_idx, w_rx_idx_nxt;
  logic [7:0]       w_rx_shift_nxt;
  logic             w_overrun_set;
  logic             w_frame_set;
  logic             r_rx_overrun;
  logic             r_rx_frame_err;

  // Two-flop synchroniser for the asynchronous serial input (idles high).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // RX next state: start validation at half-bit, then mid-bit sampling.
  // A full FIFO still takes the byte if the datapath pops on the same edge.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_push      = 1'b0;
    w_overrun_set  = 1'b0;
    w_frame_set    = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        if (!r_rx_sync) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (r_rx_cnt == CNT_HALF) begin
          if (r_rx_sync) begin
            w_rx_state_nxt = ST_IDLE;
          end else begin
            w_rx_cnt_nxt   = '0;
            w_rx_idx_nxt   = '0;
            w_rx_state_nxt = ST_DATA;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_idx == 3'd7) begin
            w_rx_state_nxt = ST_STOP;
          end else begin
            w_rx_idx_nxt = r_rx_idx + 3'd1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = ST_IDLE;
          if (r_rx_sync) begin
            if (w_rx_full && !bus_if.read_en) w_overrun_set = 1'b1;
            else                              w_rx_push     = 1'b1;
          end else begin
            w_frame_set = 1'b1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      default: w_rx_state_nxt = ST_IDLE;
    endcase
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_overrun   <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      if (w_overrun_set)         r_rx_overrun <= 1'b1;
      else if (bus_if.err_clear) r_rx_overrun <= 1'b0;
      if (w_frame_set)           r_rx_frame_err <= 1'b1;
      else if (bus_if.err_clear) r_rx_frame_err <= 1'b0;
    end
  end

  // ---------------- Outputs ----------------
  assign o_uart_tx           = r_tx_out;
  assign bus_if.tx_full      = w_tx_full;
  assign bus_if.rx_empty     = w_rx_empty;
  assign bus_if.tx_busy      = (r_tx_state != ST_IDLE) || !w_tx_empty;
  assign bus_if.rx_overrun   = r_rx_overrun;
  assign bus_if.rx_frame_err = r_rx_frame_err;
  assign bus_if.read_data    = w_rx_empty ? UART_EMPTY_WORD : {24'h0, w_rx_head};

endmodule
